// File: rtl/axi4_lite_crossbar_n_if.sv
// Bus bundle for the 1-manager / N-subordinate AXI4-Lite crossbar.
// The slave modport is the crossbar's view; the master modport is the environment's view.
interface axi4_lite_crossbar_n_if #(
  parameter int unsigned NUM_S      = 4,
  parameter int unsigned WIDTH      = 32,
  parameter int unsigned ADDR_WIDTH = 32
);
  logic                    m_awvalid;
  logic                    m_awready;
  logic [ADDR_WIDTH-1:0]   m_awaddr;
  logic                    m_wvalid;
  logic                    m_wready;
  logic [WIDTH-1:0]        m_wdata;
  logic [WIDTH/8-1:0]      m_wstrb;
  logic                    m_bvalid;
  logic                    m_bready;
  logic [1:0]              m_bresp;
  logic                    m_arvalid;
  logic                    m_arready;
  logic [ADDR_WIDTH-1:0]   m_araddr;
  logic                    m_rvalid;
  logic                    m_rready;
  logic [WIDTH-1:0]        m_rdata;
  logic [1:0]              m_rresp;

  logic [NUM_S-1:0]        s_awvalid;
  logic [NUM_S-1:0]        s_awready;
  logic [NUM_S-1:0]        s_wvalid;
  logic [NUM_S-1:0]        s_wready;
  logic [NUM_S-1:0]        s_bvalid;
  logic [NUM_S-1:0]        s_bready;
  logic [NUM_S-1:0]        s_arvalid;
  logic [NUM_S-1:0]        s_arready;
  logic [NUM_S-1:0]        s_rvalid;
  logic [NUM_S-1:0]        s_rready;
  logic [ADDR_WIDTH-1:0]   s_addr;
  logic [WIDTH-1:0]        s_wdata;
  logic [WIDTH/8-1:0]      s_wstrb;
  logic [2*NUM_S-1:0]      s_bresp;
  logic [2*NUM_S-1:0]      s_rresp;
  logic [WIDTH*NUM_S-1:0]  s_rdata;

  modport slave (
    input  m_awvalid, m_awaddr, m_wvalid, m_wdata, m_wstrb, m_bready,
    input  m_arvalid, m_araddr, m_rready,
    output m_awready, m_wready, m_bvalid, m_bresp, m_arready, m_rvalid, m_rdata, m_rresp,
    input  s_awready, s_wready, s_bvalid, s_bresp, s_arready, s_rvalid, s_rresp, s_rdata,
    output s_awvalid, s_wvalid, s_bready, s_arvalid, s_rready, s_addr, s_wdata, s_wstrb
  );

  modport master (
    output m_awvalid, m_awaddr, m_wvalid, m_wdata, m_wstrb, m_bready,
    output m_arvalid, m_araddr, m_rready,
    input  m_awready, m_wready, m_bvalid, m_bresp, m_arready, m_rvalid, m_rdata, m_rresp,
    output s_awready, s_wready, s_bvalid, s_bresp, s_arready, s_rvalid, s_rresp, s_rdata,
    input  s_awvalid, s_wvalid, s_bready, s_arvalid, s_rready, s_addr, s_wdata, s_wstrb
  );
endinterface

// File: rtl/axi4_lite_crossbar_n.sv
// 1-manager / N-subordinate AXI4-Lite crossbar: one transaction in flight, per-port address
// windows, DECERR for unmapped addresses, SLVERR on subordinate timeout, fair read/write arbitration.
module axi4_lite_crossbar_n #(
  parameter int unsigned                 NUM_S        = 4,
  parameter int unsigned                 WIDTH        = 32,
  parameter int unsigned                 ADDR_WIDTH   = 32,
  parameter logic [NUM_S*32-1:0]         S_ADDR_WIDTH = {NUM_S{32'd8}},
  parameter logic [NUM_S*ADDR_WIDTH-1:0] S_BASE_ADDR  = '0,
  parameter int unsigned                 TIMEOUT      = 255
) (
  input logic                   clk,
  input logic                   rst_n,
  axi4_lite_crossbar_n_if.slave bus
);

  localparam int unsigned TW       = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [TW-1:0] TMO_LAST = TW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
  localparam bit          TMO_EN   = (TIMEOUT != 0);

  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  typedef enum logic [2:0] {
    StIdle, StWrReq, StWrResp, StBOut, StRdReq, StRdResp, StROut
  } state_e;

  state_e               r_state;
  logic                 r_live;
  logic                 r_rd_first;
  logic [TW-1:0]        r_tmo;
  logic [NUM_S-1:0]     r_oh;
  logic [NUM_S-1:0]     r_s_awvalid;
  logic [NUM_S-1:0]     r_s_wvalid;
  logic [NUM_S-1:0]     r_s_bready;
  logic [NUM_S-1:0]     r_s_arvalid;
  logic [NUM_S-1:0]     r_s_rready;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [WIDTH-1:0]     r_wdata;
  logic [WIDTH/8-1:0]   r_wstrb;
  logic                 r_bvalid;
  logic [1:0]           r_bresp;
  logic                 r_rvalid;
  logic [1:0]           r_rresp;
  logic [WIDTH-1:0]     r_rdata;

  logic                  w_wr_elig;
  logic                  w_rd_elig;
  logic                  w_grant_rd;
  logic                  w_grant_wr;
  logic                  w_idle;
  logic [ADDR_WIDTH-1:0] w_addr;
  logic [NUM_S-1:0]      w_hit_oh;
  logic                  w_hit;
  logic                  w_aw_hs;
  logic                  w_w_hs;
  logic                  w_aw_pend;
  logic                  w_w_pend;
  logic                  w_b_hs;
  logic                  w_ar_hs;
  logic                  w_r_hs;
  logic                  w_tmo;
  logic [1:0]            w_sel_bresp;
  logic [1:0]            w_sel_rresp;
  logic [WIDTH-1:0]      w_sel_rdata;

  // Bits at or above the window width take part in the base-address compare.
  function automatic logic [ADDR_WIDTH-1:0] win_mask(input int unsigned aw);
    logic [ADDR_WIDTH-1:0] m;
    for (int unsigned b = 0; b < ADDR_WIDTH; b++) m[b] = (b >= aw);
    return m;
  endfunction

  assign w_wr_elig  = bus.m_awvalid & bus.m_wvalid;
  assign w_rd_elig  = bus.m_arvalid;
  assign w_grant_rd = w_rd_elig & (~w_wr_elig | r_rd_first);
  assign w_grant_wr = w_wr_elig & ~w_grant_rd;
  assign w_idle     = (r_state == StIdle) & r_live;
  assign w_addr     = w_grant_rd ? bus.m_araddr : bus.m_awaddr;

  // Scan high to low so the lowest matching index wins on overlapping windows.
  always_comb begin
    w_hit_oh = '0;
    for (int i = NUM_S - 1; i >= 0; i--) begin
      if (((w_addr ^ S_BASE_ADDR[ADDR_WIDTH*i +: ADDR_WIDTH]) &
           win_mask(S_ADDR_WIDTH[32*i +: 32])) == '0) begin
        w_hit_oh    = '0;
        w_hit_oh[i] = 1'b1;
      end
    end
  end
  assign w_hit = |w_hit_oh;

  always_comb begin
    w_sel_bresp = '0;
    w_sel_rresp = '0;
    w_sel_rdata = '0;
    for (int i = 0; i < NUM_S; i++) begin
      if (r_oh[i]) begin
        w_sel_bresp |= bus.s_bresp[2*i +: 2];
        w_sel_rresp |= bus.s_rresp[2*i +: 2];
        w_sel_rdata |= bus.s_rdata[WIDTH*i +: WIDTH];
      end
    end
  end

  assign w_aw_hs   = |(r_s_awvalid & bus.s_awready);
  assign w_w_hs    = |(r_s_wvalid & bus.s_wready);
  assign w_aw_pend = (|r_s_awvalid) & ~w_aw_hs;
  assign w_w_pend  = (|r_s_wvalid) & ~w_w_hs;
  assign w_b_hs    = |(r_s_bready & bus.s_bvalid);
  assign w_ar_hs   = |(r_s_arvalid & bus.s_arready);
  assign w_r_hs    = |(r_s_rready & bus.s_rvalid);
  assign w_tmo     = TMO_EN && (r_tmo == TMO_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= StIdle;
      r_live      <= 1'b0;
      r_rd_first  <= 1'b1;
      r_tmo       <= '0;
      r_oh        <= '0;
      r_s_awvalid <= '0;
      r_s_wvalid  <= '0;
      r_s_bready  <= '0;
      r_s_arvalid <= '0;
      r_s_rready  <= '0;
      r_addr      <= '0;
      r_wdata     <= '0;
      r_wstrb     <= '0;
      r_bvalid    <= 1'b0;
      r_bresp     <= '0;
      r_rvalid    <= 1'b0;
      r_rresp     <= '0;
      r_rdata     <= '0;
    end else begin
      r_live <= 1'b1;
      r_tmo  <= '0;
      unique case (r_state)
        StIdle: begin
          if (w_idle && w_wr_elig && w_rd_elig) r_rd_first <= ~r_rd_first;
          if (w_idle && w_grant_wr) begin
            r_addr  <= bus.m_awaddr;
            r_wdata <= bus.m_wdata;
            r_wstrb <= bus.m_wstrb;
            r_oh    <= w_hit_oh;
            if (w_hit) begin
              r_s_awvalid <= w_hit_oh;
              r_s_wvalid  <= w_hit_oh;
              r_state     <= StWrReq;
            end else begin
              r_bresp  <= RESP_DECERR;
              r_bvalid <= 1'b1;
              r_state  <= StBOut;
            end
          end else if (w_idle && w_grant_rd) begin
            r_addr <= bus.m_araddr;
            r_oh   <= w_hit_oh;
            if (w_hit) begin
              r_s_arvalid <= w_hit_oh;
              r_state     <= StRdReq;
            end else begin
              r_rresp  <= RESP_DECERR;
              r_rdata  <= '0;
              r_rvalid <= 1'b1;
              r_state  <= StROut;
            end
          end
        end
        StWrReq: begin
          if (!w_aw_pend && !w_w_pend) begin
            r_s_awvalid <= '0;
            r_s_wvalid  <= '0;
            r_s_bready  <= r_oh;
            r_state     <= StWrResp;
          end else if (w_tmo) begin
            r_s_awvalid <= '0;
            r_s_wvalid  <= '0;
            r_bresp     <= RESP_SLVERR;
            r_bvalid    <= 1'b1;
            r_state     <= StBOut;
          end else begin
            if (w_aw_hs) r_s_awvalid <= '0;
            if (w_w_hs) r_s_wvalid <= '0;
            r_tmo <= r_tmo + 1'b1;
          end
        end
        StWrResp: begin
          if (w_b_hs || w_tmo) begin
            r_s_bready <= '0;
            r_bresp    <= w_b_hs ? w_sel_bresp : RESP_SLVERR;
            r_bvalid   <= 1'b1;
            r_state    <= StBOut;
          end else begin
            r_tmo <= r_tmo + 1'b1;
          end
        end
        StBOut: begin
          if (bus.m_bready) begin
            r_bvalid <= 1'b0;
            r_state  <= StIdle;
          end
        end
        StRdReq: begin
          if (w_ar_hs) begin
            r_s_arvalid <= '0;
            r_s_rready  <= r_oh;
            r_state     <= StRdResp;
          end else if (w_tmo) begin
            r_s_arvalid <= '0;
            r_rresp     <= RESP_SLVERR;
            r_rdata     <= '0;
            r_rvalid    <= 1'b1;
            r_state     <= StROut;
          end else begin
            r_tmo <= r_tmo + 1'b1;
          end
        end
        StRdResp: begin
          if (w_r_hs || w_tmo) begin
            r_s_rready <= '0;
            r_rresp    <= w_r_hs ? w_sel_rresp : RESP_SLVERR;
            r_rdata    <= w_r_hs ? w_sel_rdata : '0;
            r_rvalid   <= 1'b1;
            r_state    <= StROut;
          end else begin
            r_tmo <= r_tmo + 1'b1;
          end
        end
        StROut: begin
          if (bus.m_rready) begin
            r_rvalid <= 1'b0;
            r_state  <= StIdle;
          end
        end
        default: r_state <= StIdle;
      endcase
    end
  end

  // Address-phase readies are combinational so acceptance happens in the request cycle.
  assign bus.m_awready = w_idle & w_grant_wr;
  assign bus.m_wready  = w_idle & w_grant_wr;
  assign bus.m_arready = w_idle & w_grant_rd;
  assign bus.m_bvalid  = r_bvalid;
  assign bus.m_bresp   = r_bresp;
  assign bus.m_rvalid  = r_rvalid;
  assign bus.m_rresp   = r_rresp;
  assign bus.m_rdata   = r_rdata;

  assign bus.s_awvalid = r_s_awvalid;
  assign bus.s_wvalid  = r_s_wvalid;
  assign bus.s_bready  = r_s_bready;
  assign bus.s_arvalid = r_s_arvalid;
  assign bus.s_rready  = r_s_rready;
  assign bus.s_addr    = r_addr;
  assign bus.s_wdata   = r_wdata;
  assign bus.s_wstrb   = r_wstrb;

endmodule
